hmem_arbiter: RTL and testbench

Two-requester arbiter that shares one higher-level memory port between the instruction cache and the data cache. It sits between the two `cache` instances' `hmem_if` requester sides and the single backing memory. It grants one requester at a time and forwards its request unchanged. It holds the grant until the memory fulfils the request, then returns the response to the granted requester only.

---
 rtl/hmem_arbiter.sv | 143 ++++++++++++++
 tb/tb_hmem_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hmem_arbiter.sv
// hmem_arbiter: shares one higher-level memory port between the icache
// (requester 0) and the dcache (requester 1). One requester is granted at a
// time, its request is forwarded unchanged, and the grant is held until the
// memory fulfils it. A one-cycle RELEASE gap follows every fulfilment.
//
// Optional feature: define HMEM_ARB_ROUND_ROBIN_EN for round-robin tie
// breaking; otherwise the dcache always wins a tie (fixed priority).
//
// Handshake: r_req_valid[i] is held by requester i until it sees the one-cycle
// r_req_fulfilled[i] pulse; m_req_valid is held by the arbiter until the
// memory pulses m_req_fulfilled, which completes the transfer in that cycle.
module hmem_arbiter #(
   parameter int XLEN           = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [1:0]                 r_req_valid,
   input  logic [1:0]                 r_req_op,
   input  logic [1:0][1:0]            r_req_size,
   input  logic [1:0][XLEN-1:0]       r_req_addr,
   input  logic [1:0][XLEN-1:0]       r_req_store_word,
   output logic [1:0]                 r_req_fulfilled,
   output logic [XLEN-1:0]            r_req_loaded_word,
   output logic                       m_req_valid,
   output logic                       m_req_op,
   output logic [1:0]                 m_req_size,
   output logic [XLEN-1:0]            m_req_addr,
   output logic [XLEN-1:0]            m_req_store_word,
   input  logic                       m_req_fulfilled,
   input  logic [XLEN-1:0]            m_req_loaded_word,
   output logic                       grant_id,
   output logic                       timeout_err,
   output logic [1:0]                 dbg_state
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      RELEASE = 2'd2
   } state_t;

   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);

   state_t          state, state_n;
   logic            winner;
   logic [CW-1:0]   wd_cnt;

   assign dbg_state = state;

`ifdef HMEM_ARB_ROUND_ROBIN_EN
   logic rr_ptr;

   // Round-robin tie break: the pointer names the preferred requester.
   always_comb begin
      winner = (&r_req_valid) ? rr_ptr : r_req_valid[1];
   end

   // After each grant, prefer the other requester next time.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr <= 1'b0;
      end else if (state == IDLE && (|r_req_valid)) begin
         rr_ptr <= ~winner;
      end
   end
`else
   // Fixed priority: dcache beats icache.
   always_comb begin
      winner = r_req_valid[1];
   end
`endif

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next state and all request/response outputs; fields are only forwarded
   // while BUSY so the other requester never leaks onto the memory port.
   always_comb begin
      state_n           = state;
      m_req_valid       = 1'b0;
      m_req_op          = 1'b0;
      m_req_size        = 2'b00;
      m_req_addr        = '0;
      m_req_store_word  = '0;
      r_req_fulfilled   = 2'b00;
      r_req_loaded_word = '0;
      case (state)
         IDLE: begin
            if (|r_req_valid) state_n = BUSY;
         end
         BUSY: begin
            m_req_valid      = 1'b1;
            m_req_op         = r_req_op[grant_id];
            m_req_size       = r_req_size[grant_id];
            m_req_addr       = r_req_addr[grant_id];
            m_req_store_word = r_req_store_word[grant_id];
            if (m_req_fulfilled) begin
               r_req_fulfilled[grant_id] = 1'b1;
               r_req_loaded_word         = m_req_loaded_word;
               state_n                   = RELEASE;
            end
         end
         RELEASE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Grant register: loaded only when leaving IDLE, held otherwise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grant_id <= 1'b0;
      end else if (state == IDLE && (|r_req_valid)) begin
         grant_id <= winner;
      end
   end

   // Watchdog: counts BUSY cycles, saturates, and latches a sticky error on
   // the cycle the count reaches TIMEOUT_CYCLES. It never touches the grant.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wd_cnt      <= '0;
         timeout_err <= 1'b0;
      end else if (state == IDLE) begin
         if (|r_req_valid) wd_cnt <= '0;
      end else if (state == BUSY) begin
         if (wd_cnt != TMAX) wd_cnt <= wd_cnt + 1'b1;
         if (TIMEOUT_CYCLES != 0 && wd_cnt == TMAX - 1'b1) timeout_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_hmem_arbiter.sv
// tb_hmem_arbiter: directed, table-driven bench for hmem_arbiter, plus
// hand-written sequences for arbitration rounds, watchdog and reset corners.
module tb_hmem_arbiter;

   localparam int XLEN = 32;

   logic                  clk;
   logic                  reset;
   logic [1:0]            r_req_valid;
   logic [1:0]            r_req_op;
   logic [1:0][1:0]       r_req_size;
   logic [1:0][XLEN-1:0]  r_req_addr;
   logic [1:0][XLEN-1:0]  r_req_store_word;
   logic [1:0]            r_req_fulfilled;
   logic [XLEN-1:0]       r_req_loaded_word;
   logic                  m_req_valid;
   logic                  m_req_op;
   logic [1:0]            m_req_size;
   logic [XLEN-1:0]       m_req_addr;
   logic [XLEN-1:0]       m_req_store_word;
   logic                  m_req_fulfilled;
   logic [XLEN-1:0]       m_req_loaded_word;
   logic                  grant_id;
   logic                  timeout_err;
   logic [1:0]            dbg_state;

   int checks = 0;
   int errors = 0;

   hmem_arbiter #(.XLEN(XLEN), .TIMEOUT_CYCLES(8)) dut (
      .clk               (clk),
      .reset             (reset),
      .r_req_valid       (r_req_valid),
      .r_req_op          (r_req_op),
      .r_req_size        (r_req_size),
      .r_req_addr        (r_req_addr),
      .r_req_store_word  (r_req_store_word),
      .r_req_fulfilled   (r_req_fulfilled),
      .r_req_loaded_word (r_req_loaded_word),
      .m_req_valid       (m_req_valid),
      .m_req_op          (m_req_op),
      .m_req_size        (m_req_size),
      .m_req_addr        (m_req_addr),
      .m_req_store_word  (m_req_store_word),
      .m_req_fulfilled   (m_req_fulfilled),
      .m_req_loaded_word (m_req_loaded_word),
      .grant_id          (grant_id),
      .timeout_err       (timeout_err),
      .dbg_state         (dbg_state)
   );

   // Clock / reset.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  rv;
      logic        mf;
      logic [31:0] mw;
      logic [1:0]  st;
      logic        gid;
      logic        mv;
      logic [31:0] maddr;
      logic        mop;
      logic [31:0] mstore;
      logic [1:0]  rf;
      logic [31:0] rw;
   } vec_t;

   vec_t tbl [18];

   function automatic vec_t mk(logic [1:0] rv, logic mf, logic [31:0] mw,
                               logic [1:0] st, logic gid, logic mv,
                               logic [31:0] maddr, logic mop, logic [31:0] mstore,
                               logic [1:0] rf, logic [31:0] rw);
      vec_t v;
      v.rv = rv; v.mf = mf; v.mw = mw; v.st = st; v.gid = gid; v.mv = mv;
      v.maddr = maddr; v.mop = mop; v.mstore = mstore; v.rf = rf; v.rw = rw;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [1:0] rv, input logic mf, input logic [31:0] mw);
      r_req_valid       = rv;
      m_req_fulfilled   = mf;
      m_req_loaded_word = mw;
   endtask

   logic exp_round [3];

   initial begin
      // Fixed requester payloads: icache load at 0x1000, dcache store to 0x100.
      r_req_op            = 2'b10;
      r_req_size          = '0;
      r_req_size[0]       = 2'd2;
      r_req_size[1]       = 2'd2;
      r_req_addr[0]       = 32'h0000_1000;
      r_req_addr[1]       = 32'h0000_0100;
      r_req_store_word[0] = 32'h0;
      r_req_store_word[1] = 32'h1234_5678;
      drive(2'b00, 1'b0, 32'h0);
      reset = 1'b1;

      // Directed cycle table: {rv, mf, mw} -> {state, grant, m_req_*, r_req_*}.
      tbl[0]  = mk(2'b01, 0, 32'h0,          0, 0, 0, 32'h0,    0, 32'h0,         2'b00, 32'h0);
      tbl[1]  = mk(2'b01, 0, 32'h0,          1, 0, 1, 32'h1000, 0, 32'h0,         2'b00, 32'h0);
      tbl[2]  = mk(2'b01, 0, 32'h0,          1, 0, 1, 32'h1000, 0, 32'h0,         2'b00, 32'h0);
      tbl[3]  = mk(2'b01, 0, 32'h0,          1, 0, 1, 32'h1000, 0, 32'h0,         2'b00, 32'h0);
      tbl[4]  = mk(2'b01, 1, 32'hDEADBEEF,   1, 0, 1, 32'h1000, 0, 32'h0,         2'b01, 32'hDEADBEEF);
      tbl[5]  = mk(2'b00, 0, 32'h0,          2, 0, 0, 32'h0,    0, 32'h0,         2'b00, 32'h0);
      tbl[6]  = mk(2'b00, 0, 32'h0,          0, 0, 0, 32'h0,    0, 32'h0,         2'b00, 32'h0);
      tbl[7]  = mk(2'b11, 0, 32'h0,          0, 0, 0, 32'h0,    0, 32'h0,         2'b00, 32'h0);
      tbl[8]  = mk(2'b11, 0, 32'h0,          1, 1, 1, 32'h100,  1, 32'h12345678,  2'b00, 32'h0);
      tbl[9]  = mk(2'b11, 0, 32'h0,          1, 1, 1, 32'h100,  1, 32'h12345678,  2'b00, 32'h0);
      tbl[10] = mk(2'b11, 1, 32'h0,          1, 1, 1, 32'h100,  1, 32'h12345678,  2'b10, 32'h0);
      tbl[11] = mk(2'b01, 0, 32'h0,          2, 1, 0, 32'h0,    0, 32'h0,         2'b00, 32'h0);
      tbl[12] = mk(2'b01, 0, 32'h0,          0, 1, 0, 32'h0,    0, 32'h0,         2'b00, 32'h0);
      tbl[13] = mk(2'b01, 0, 32'h0,          1, 0, 1, 32'h1000, 0, 32'h0,         2'b00, 32'h0);
      tbl[14] = mk(2'b01, 1, 32'hCAFEF00D,   1, 0, 1, 32'h1000, 0, 32'h0,         2'b01, 32'hCAFEF00D);
      tbl[15] = mk(2'b00, 1, 32'h11111111,   2, 0, 0, 32'h0,    0, 32'h0,         2'b00, 32'h0);
      tbl[16] = mk(2'b00, 0, 32'h0,          0, 0, 0, 32'h0,    0, 32'h0,         2'b00, 32'h0);
      tbl[17] = mk(2'b00, 1, 32'h55AA55AA,   0, 0, 0, 32'h0,    0, 32'h0,         2'b00, 32'h0);

`ifdef HMEM_ARB_ROUND_ROBIN_EN
      exp_round[0] = 1'b1; exp_round[1] = 1'b0; exp_round[2] = 1'b1;
`else
      exp_round[0] = 1'b1; exp_round[1] = 1'b1; exp_round[2] = 1'b1;
`endif

      // Reset state.
      repeat (2) @(negedge clk);
      #1;
      chk("rst_state", 32'(dbg_state), 32'd0);
      chk("rst_grant", 32'(grant_id), 32'd0);
      chk("rst_mvalid", 32'(m_req_valid), 32'd0);
      chk("rst_rful", 32'(r_req_fulfilled), 32'd0);
      chk("rst_terr", 32'(timeout_err), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Table-driven sequence: icache load, dcache store with icache pending,
      // spurious fulfils in RELEASE and IDLE.
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         drive(tbl[i].rv, tbl[i].mf, tbl[i].mw);
         #1;
         chk($sformatf("v%0d_state", i),  32'(dbg_state),        32'(tbl[i].st));
         chk($sformatf("v%0d_grant", i),  32'(grant_id),         32'(tbl[i].gid));
         chk($sformatf("v%0d_mvalid", i), 32'(m_req_valid),      32'(tbl[i].mv));
         chk($sformatf("v%0d_maddr", i),  m_req_addr,            tbl[i].maddr);
         chk($sformatf("v%0d_mop", i),    32'(m_req_op),         32'(tbl[i].mop));
         chk($sformatf("v%0d_mstore", i), m_req_store_word,      tbl[i].mstore);
         chk($sformatf("v%0d_rful", i),   32'(r_req_fulfilled),  32'(tbl[i].rf));
         chk($sformatf("v%0d_rword", i),  r_req_loaded_word,     tbl[i].rw);
      end

      // Three back-to-back rounds with both requesters asserting.
      @(negedge clk);
      drive(2'b11, 1'b0, 32'h0);
      for (int r = 0; r < 3; r++) begin
         int w;
         w = 0;
         #1;
         while (!m_req_valid && w < 10) begin
            @(negedge clk);
            #1;
            w++;
         end
         chk($sformatf("rr%0d_wait", r), 32'(w < 10), 32'd1);
         chk($sformatf("rr%0d_grant", r), 32'(grant_id), 32'(exp_round[r]));
         chk($sformatf("rr%0d_maddr", r), m_req_addr,
             exp_round[r] ? 32'h100 : 32'h1000);
         m_req_fulfilled   = 1'b1;
         m_req_loaded_word = 32'hA5A5_0000 + 32'(r);
         #1;
         chk($sformatf("rr%0d_rful", r), 32'(r_req_fulfilled),
             exp_round[r] ? 32'd2 : 32'd1);
         @(negedge clk);
         m_req_fulfilled = 1'b0;
      end
      drive(2'b00, 1'b0, 32'h0);
      repeat (3) @(negedge clk);

      // Watchdog: icache granted, memory never answers.
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      drive(2'b01, 1'b0, 32'h0);
      repeat (8) @(negedge clk);
      #1;
      chk("wd_before", 32'(timeout_err), 32'd0);
      @(negedge clk);
      #1;
      chk("wd_rise", 32'(timeout_err), 32'd1);
      repeat (5) @(negedge clk);
      #1;
      chk("wd_sticky", 32'(timeout_err), 32'd1);
      chk("wd_mvalid", 32'(m_req_valid), 32'd1);
      chk("wd_grant", 32'(grant_id), 32'd0);
      chk("wd_state", 32'(dbg_state), 32'd1);
      reset = 1'b1;
      #1;
      chk("wd_rst_terr", 32'(timeout_err), 32'd0);
      chk("wd_rst_mvalid", 32'(m_req_valid), 32'd0);
      chk("wd_rst_state", 32'(dbg_state), 32'd0);
      @(negedge clk);
      drive(2'b00, 1'b0, 32'h0);
      reset = 1'b0;

      // Reset two cycles into BUSY, then a late memory fulfil.
      @(negedge clk);
      drive(2'b10, 1'b0, 32'h0);
      repeat (2) @(negedge clk);
      #1;
      chk("mid_mvalid", 32'(m_req_valid), 32'd1);
      chk("mid_grant", 32'(grant_id), 32'd1);
      reset = 1'b1;
      #1;
      chk("mid_rst_mvalid", 32'(m_req_valid), 32'd0);
      chk("mid_rst_state", 32'(dbg_state), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      drive(2'b00, 1'b1, 32'h7777_7777);
      #1;
      chk("late_rful", 32'(r_req_fulfilled), 32'd0);
      chk("late_rword", r_req_loaded_word, 32'd0);
      chk("late_mvalid", 32'(m_req_valid), 32'd0);
      @(negedge clk);
      drive(2'b00, 1'b0, 32'h0);
      #1;
      chk("late_state", 32'(dbg_state), 32'd0);
      chk("late_grant", 32'(grant_id), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
